muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32/64 M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle divide special cases.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_func;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_prod;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // Operand decode at acceptance: signedness, magnitudes and special cases
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                      (func3 == 3'b100) || (func3 == 3'b110);
  assign w_b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
  assign w_a_neg    = w_a_signed & src_a[XLEN-1];
  assign w_b_neg    = w_b_signed & src_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -src_a : src_a;
  assign w_mag_b    = w_b_neg ? -src_b : src_b;
  assign w_div0     = func3[2] & (src_b == '0);
  assign w_ovf      = func3[2] & ~func3[0] & (src_a == MIN_NEG) & (src_b == ALL_ONES);
  assign w_special_res = w_div0 ? (func3[1] ? src_a : ALL_ONES)
                                : (func3[1] ? '0 : src_a);

  // One iteration of both datapaths; only the one matching r_func is used
  logic [XLEN:0]   w_add;
  logic [PW-1:0]   w_prod_nxt;
  logic [XLEN+1:0] w_diff;
  logic            w_qbit;
  logic [XLEN:0]   w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  assign w_add      = {1'b0, r_prod[PW-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_add, r_prod[XLEN-1:1]};
  assign w_diff     = {1'b0, r_rem, r_quo[XLEN-1]} - {2'b00, r_b};
  assign w_qbit     = ~w_diff[XLEN+1];
  assign w_rem_nxt  = w_qbit ? w_diff[XLEN:0] : {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_qbit};

  // Sign correction of the final iteration's values
  logic [PW-1:0]   w_prod_fin;
  logic [XLEN-1:0] w_quo_fin;
  logic [XLEN-1:0] w_rem_fin;
  logic [XLEN-1:0] w_calc_res;

  assign w_prod_fin = r_neg_res ? -w_prod_nxt : w_prod_nxt;
  assign w_quo_fin  = r_neg_res ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fin  = r_neg_rem ? -w_rem_nxt[XLEN-1:0] : w_rem_nxt[XLEN-1:0];

  always_comb begin
    w_calc_res = w_rem_fin;
    case (r_func)
      3'b000:                 w_calc_res = w_prod_fin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod_fin[PW-1:XLEN];
      3'b100, 3'b101:         w_calc_res = w_quo_fin;
      default:                w_calc_res = w_rem_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_func    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (start) begin
              r_func    <= func3;
              r_a       <= w_mag_a;
              r_b       <= w_mag_b;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_cnt     <= '0;
              r_prod    <= {{XLEN{1'b0}}, w_mag_b};
              r_rem     <= '0;
              r_quo     <= w_mag_a;
              if (w_div0 || w_ovf) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_result <= w_special_res;
              end else begin
                r_state <= S_CALC;
                r_busy  <= 1'b1;
              end
            end
          end
          S_CALC: begin
            r_prod <= w_prod_nxt;
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN - 1)) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_calc_res;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  func3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M results from plain wide arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b};                 r = p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};           r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b};                 r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle-level reference: idle / counting down / done pulse
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;
  int          m_left   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_known  <= 1'b1;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_pend;
      end
    end else if (start) begin
      if (is_fast(func3, src_a, src_b)) begin
        m_done   <= 1'b1;
        m_result <= ref_result(func3, src_a, src_b);
      end else begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_left <= XLEN;
        m_pend <= ref_result(func3, src_a, src_b);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_busy",   64'(busy),   64'(m_busy));
      check("model_done",   64'(done),   64'(m_done));
      check("model_result", 64'(result), 64'(m_result));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle, scramble inputs afterwards, wait for done
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit poke, input string name);
    int n     = 0;
    int nbusy = 0;
    bit seen  = 1'b0;
    func3 = f;
    src_a = a;
    src_b = b;
    start = 1'b1;
    while (!seen && n < 100) begin
      tick();
      n++;
      start = poke && (n <= lat - 2) && (n % 2 == 1);
      func3 = 3'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(seen ? n : 0), 64'(lat));
    check({name, "_result"}, 64'(result), 64'(exp));
    if (lat > 1) check({name, "_busy_cycles"}, 64'(nbusy), 64'(lat - 1));
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = '0;
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, "mul");        tick();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, "mulhu");      tick();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0, "mulh");       tick();
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, "mulhsu");     tick();
    run_op(3'd0, 32'd12345,     32'd0,         32'd0,         33, 1'b0, "mul_zero");   tick();
    run_op(3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF, 1,  1'b0, "div0");       tick();
    run_op(3'd6, 32'd100,       32'd0,         32'd100,       1,  1'b0, "rem0");       tick();
    run_op(3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1,  1'b0, "divu0");      tick();
    run_op(3'd7, 32'd100,       32'd0,         32'd100,       1,  1'b0, "remu0");      tick();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0, "ovf_div");    tick();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0, "ovf_rem");    tick();
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0, "divu_nooverflow"); tick();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0, "div_round");  tick();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, "rem_round");  tick();
    run_op(3'd5, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33, 1'b0, "divu");       tick();
    run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, "div_negb");   tick();
    run_op(3'd7, 32'd17,        32'd5,         32'd2,         33, 1'b0, "remu");       tick();
    run_op(3'd0, 32'd1000,      32'd1000,      32'h000F_4240, 33, 1'b1, "start_busy"); tick();

    // Back-to-back: second start issued in the first op's done cycle
    run_op(3'd4, 32'd100, 32'd7, 32'd14, 33, 1'b0, "b2b_first");
    run_op(3'd6, 32'd100, 32'd7, 32'd2,  33, 1'b0, "b2b_second");
    tick();

    // Flush in cycle 10 of a divide
    func3 = 3'd4; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_result_kept", 64'(result), 64'd2);

    // Flush wins over start in the same idle cycle
    func3 = 3'd0; src_a = 32'd9; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    check("flush_start_done", 64'(done), 64'd0);
    tick();

    // Reset in cycle 5 of a multiply, with start also raised
    func3 = 3'd0; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_result", 64'(result), 64'd0);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);

    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b0, "post_reset");
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
